// File: rtl/fair_scheduler_if.sv
// ---------------------------------------------------------------------------
// fair_scheduler_if
//   Bundles the free nondeterministic choices coming into the fairness front
//   end and the sanitized, fairness-enforced choices it hands downstream.
//
//   Signals
//     nd_select  free nondeterministic process choice (SELMSB+1 bits)
//     nd_pause   free nondeterministic pause/progress choice
//     select     registered process index for the downstream model
//     pause      registered pause for the downstream model
//     forced     select of this cycle came from the starvation override
//     pause_cut  pause of this cycle was forced to 0
//
//   Modports
//     master  the environment: drives nd_*, observes the scheduler outputs
//     slave   the scheduler: consumes nd_*, drives the outputs
// ---------------------------------------------------------------------------
interface fair_scheduler_if #(
    parameter int SELMSB = 1
);
    logic [SELMSB:0] nd_select;
    logic            nd_pause;
    logic [SELMSB:0] select;
    logic            pause;
    logic            forced;
    logic            pause_cut;

    modport master (
        output nd_select,
        output nd_pause,
        input  select,
        input  pause,
        input  forced,
        input  pause_cut
    );

    modport slave (
        input  nd_select,
        input  nd_pause,
        output select,
        output pause,
        output forced,
        output pause_cut
    );
endinterface

// File: rtl/fair_scheduler.sv
// ---------------------------------------------------------------------------
// fair_scheduler
//   Bounded-fairness front end for the interleaving models. Free choices of
//   process index and pause are passed through with one cycle of latency,
//   except when a process has gone BOUND cycles without a grant (then the
//   lowest such process is granted) or pause has been held PAUSE_MAX cycles
//   in a row (then pause is forced low for one cycle).
//
//   Ports
//     clock    sole clock, all state changes on its rising edge
//     reset_n  asynchronous active-low reset, clears all state and outputs
//     bus      fair_scheduler_if.slave: nd_select/nd_pause in,
//              select/pause/forced/pause_cut out (all outputs registered)
// ---------------------------------------------------------------------------
module fair_scheduler #(
    parameter int SELMSB    = 1,
    parameter int HIPROC    = 2,
    parameter int BOUND     = 7,
    parameter int CNTMSB    = 2,
    parameter int PAUSE_MAX = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    fair_scheduler_if.slave   bus
);
    localparam int NPROC = HIPROC + 1;
    // Pause streak counter only needs to reach PAUSE_MAX.
    localparam int PCW = (PAUSE_MAX < 1) ? 1 : $clog2(PAUSE_MAX + 1);

    localparam logic [CNTMSB:0] AGE_SAT  = (CNTMSB + 1)'(BOUND);
    localparam logic [CNTMSB:0] AGE_ONE  = (CNTMSB + 1)'(1);
    localparam logic [SELMSB:0] HI_IDX   = (SELMSB + 1)'(HIPROC);
    localparam logic [PCW-1:0]  PCNT_MAX = PCW'(PAUSE_MAX);
    localparam logic [PCW-1:0]  PCNT_ONE = PCW'(1);

    // -----------------------------------------------------------------------
    // Candidate: out-of-range indices fold to process 0, matching the
    // mapping the downstream model applies itself.
    // -----------------------------------------------------------------------
    logic [SELMSB:0] cand;
    assign cand = (bus.nd_select > HI_IDX) ? '0 : bus.nd_select;

    // -----------------------------------------------------------------------
    // Per-process age counters and saturation flags
    // -----------------------------------------------------------------------
    logic [HIPROC:0] sat;
    logic [SELMSB:0] grant_d;
    logic            forced_d;

    genvar gi;
    generate
        for (gi = 0; gi < NPROC; gi++) begin : g_age
            localparam logic [SELMSB:0] IDX = (SELMSB + 1)'(gi);

            logic [CNTMSB:0] age_q;
            logic [CNTMSB:0] age_d;

            // Granted process restarts its wait; everyone else ages but
            // never past BOUND, so the counter cannot wrap.
            always_comb begin
                age_d = age_q;
                if (grant_d == IDX) begin
                    age_d = '0;
                end else if (age_q != AGE_SAT) begin
                    age_d = age_q + AGE_ONE;
                end
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    age_q <= '0;
                end else begin
                    age_q <= age_d;
                end
            end

            assign sat[gi] = (age_q == AGE_SAT);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Grant: the lowest saturated process wins, otherwise the free choice.
    // Scanning from the top down lets the lowest index be the last writer.
    // -----------------------------------------------------------------------
    always_comb begin
        grant_d  = cand;
        forced_d = 1'b0;
        for (int i = HIPROC; i >= 0; i--) begin
            if (sat[i]) begin
                grant_d  = (SELMSB + 1)'(i);
                forced_d = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Pause streak limiter, independent of the grant override
    // -----------------------------------------------------------------------
    logic [PCW-1:0] pcnt_q;
    logic [PCW-1:0] pcnt_d;
    logic           pause_d;
    logic           pause_cut_d;

    always_comb begin
        pause_d     = bus.nd_pause;
        pause_cut_d = 1'b0;
        pcnt_d      = '0;
        if (pcnt_q == PCNT_MAX) begin
            pause_d     = 1'b0;
            pause_cut_d = 1'b1;
            pcnt_d      = '0;
        end else if (bus.nd_pause) begin
            pcnt_d = pcnt_q + PCNT_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Registered outputs: stable for the whole cycle downstream
    // -----------------------------------------------------------------------
    logic [SELMSB:0] select_q;
    logic            pause_q;
    logic            forced_q;
    logic            pause_cut_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            select_q    <= '0;
            pause_q     <= 1'b0;
            forced_q    <= 1'b0;
            pause_cut_q <= 1'b0;
        end else begin
            select_q    <= grant_d;
            pause_q     <= pause_d;
            forced_q    <= forced_d;
            pause_cut_q <= pause_cut_d;
        end
    end

    assign bus.select    = select_q;
    assign bus.pause     = pause_q;
    assign bus.forced    = forced_q;
    assign bus.pause_cut = pause_cut_q;

endmodule

// File: doc/fair_scheduler.md
# fair_scheduler

Bounded-fairness front end for the interleaving models. It sits directly upstream of the bakery mutual-exclusion model and drives that model's `select` and `pause` inputs. It passes free nondeterministic choices through unchanged, except where that would starve a process or stall one indefinitely. In those cases it overrides the choice, so liveness properties hold without separate fairness constraints.

## Interface
- `SELMSB`, default 1: MSB of process-index vectors; HIPROC+1 < 2**(SELMSB+1).
- `HIPROC`, default 2: highest process index; indices start at 0.
- `BOUND`, default 7: maximum consecutive cycles a process may go ungranted before a forced grant.
- `CNTMSB`, default 2: MSB of each age counter; BOUND < 2**(CNTMSB+1).
- `PAUSE_MAX`, default 3: maximum consecutive cycles with `pause`=1.
- `clock`  in  1  sole clock; all state changes on posedge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `nd_select`  in  SELMSB+1  free nondeterministic process choice.
- `nd_pause`  in  1  free nondeterministic pause/progress choice.
- `select`  out  SELMSB+1  registered process index for the downstream model.
- `pause`  out  1  registered pause for the downstream model.
- `forced`  out  1  registered; 1 when this cycle's `select` came from the starvation override.
- `pause_cut`  out  1  registered; 1 when this cycle's `pause` was forced to 0.

## Operation
- **Sanitize.** cand = (nd_select > HIPROC) ? 0 : nd_select. This is the same out-of-range mapping the downstream model applies.
- **State.**
  - age[0..HIPROC]: one counter per process, CNTMSB+1 bits, saturating at BOUND.
  - pcnt: counts consecutive pause cycles, 0..PAUSE_MAX.
- **Grant.** Computed combinationally from the registered ages.
  - If any age[i] == BOUND: g = lowest such i, and fsel = 1.
  - Otherwise: g = cand, and fsel = 0.
- **Age update.** age[g] <= 0. For every other i: age[i] <= min(age[i]+1, BOUND).
- **Pause.**
  - If pcnt == PAUSE_MAX: p = 0, pcut = 1, pcnt <= 0.
  - Otherwise: p = nd_pause, pcut = 0, and pcnt <= nd_pause ? pcnt+1 : 0.
- **Outputs.** On posedge: select <= g, pause <= p, forced <= fsel, pause_cut <= pcut.
- **Independence.** The pause override and the grant override are independent and may fire in the same cycle.
- **Simultaneous saturation.** When several processes are saturated, they are served in ascending index order, one per cycle. Saturated processes that are not granted stay at BOUND.
- **Reset.** reset_n = 0 clears everything immediately, without waiting for a clock edge:
  - select = 0, pause = 0, forced = 0, pause_cut = 0;
  - all age = 0, pcnt = 0.
  - This applies mid-operation too; nd inputs are ignored while reset is held.

## Timing
- Latency: exactly one cycle from nd_select/nd_pause to select/pause. Outputs are stable for the whole cycle, so the downstream model samples them glitch-free.
- Fairness guarantee: each index 0..HIPROC appears on `select` at least once in every window of BOUND+HIPROC+1 consecutive post-reset cycles.
- Pause guarantee: `pause` is never 1 for more than PAUSE_MAX consecutive cycles.
- First output after reset release: the first posedge reflects cand from nd_select at that edge, with ages all 0, so no override is possible.
- Counter width: no wrap-around is possible. Saturation at BOUND is mandatory, and increment beyond BOUND must not occur.

## Test plan
- **Reset mid-run.** With ages nonzero and pause streak at 2, drop reset_n between edges.
  - Immediately: select = 0, pause = 0, forced = 0, pause_cut = 0.
  - After release with nd_select = 1, nd_pause = 0: next edge gives select = 1, forced = 0.
- **Starvation override** (defaults). nd_select held at 0 from reset release.
  - Required select sequence: 0,0,0,0,0,0,0,1,2,0,0,...
  - forced = 1 only on the 1 and 2 cycles.
  - The next forced 1 occurs 7 cycles after the previous grant to 1.
- **Out-of-range select.** nd_select held at 3 → treated as 0. Same select sequence as the starvation-override test.
- **Pause cap.** nd_pause held at 1, nd_select cycling 0,1,2.
  - pause = 1,1,1,0,1,1,1,0,...
  - pause_cut = 1 exactly on the 0 cycles.
  - select follows cand with one-cycle lag, forced = 0.
- **Simultaneous overrides.** Drive ages to saturate while nd_pause = 1 for 3 prior cycles.
  - The same cycle shows forced = 1 and pause_cut = 1.
  - select = lowest saturated index.
- **Random soak.** 10,000 cycles of random nd_select (including 3) and nd_pause, with random reset pulses. Monitors must show all of:
  - the fairness window bound holds;
  - the pause streak is ≤ PAUSE_MAX;
  - select ≤ HIPROC always;
  - forced = 1 only when some age was at BOUND.
